// File: rtl/i_set_profile_gen_if.sv
// rtl/i_set_profile_gen_if.sv - control/setpoint bundle for the discharge current profile generator
interface i_set_profile_gen_if #(
    parameter int DW = 16,
    parameter int TW = 16
);
    logic          start;
    logic          abort;
    logic [15:0]   waveform;
    logic [TW-1:0] Ton_timer;
    logic [DW-1:0] Ip;
    logic [DW-1:0] rise_step;
    logic [DW-1:0] fall_step;
    logic [DW-1:0] i_set;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output start, abort, waveform, Ton_timer, Ip, rise_step, fall_step,
        input  i_set, busy, done, err
    );

    modport slave (
        input  start, abort, waveform, Ton_timer, Ip, rise_step, fall_step,
        output i_set, busy, done, err
    );
endinterface

// File: rtl/i_set_profile_gen.sv
// rtl/i_set_profile_gen.sv - rectangle/triangle/trapezoid discharge current setpoint generator
module i_set_profile_gen #(
    parameter int DW = 16,
    parameter int TW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    i_set_profile_gen_if.slave  bus
);
    localparam logic [15:0] MODE_RECT = 16'h0001;
    localparam logic [15:0] MODE_TRI  = 16'h0002;
    localparam logic [15:0] MODE_TRAP = 16'h0004;

    typedef enum logic [1:0] {IDLE, RISE, HOLD, FALL} state_t;

    state_t        state_q;
    logic [TW-1:0] t_q;
    logic [15:0]   mode_q;
    logic [TW-1:0] ton_l_q;
    logic [DW-1:0] ip_l_q;
    logic [DW-1:0] rise_l_q;
    logic [DW-1:0] fall_l_q;
    logic [DW-1:0] i_set_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic [DW-1:0] fall_eff;
    logic [DW:0]   diff_w;
    logic [DW-1:0] sub_val;
    logic [DW:0]   sum_w;
    logic [DW-1:0] add_val;
    logic [TW:0]   t_inc;
    logic [TW-1:0] t_sat;
    logic          ton_hit;
    logic          rise_lim_hit;
    logic          start_ok;
    logic          is_tri;
    logic          is_rect;
    logic [DW-1:0] first_rise;

    // Saturating arithmetic on the latched profile; all comparisons are done one bit
    // wider so that Ton-1 style thresholds never underflow and ramps never wrap.
    always_comb begin
        fall_eff     = (fall_l_q == '0) ? '1 : fall_l_q;
        diff_w       = {1'b0, i_set_q} - {1'b0, fall_eff};
        sub_val      = diff_w[DW] ? '0 : diff_w[DW-1:0];
        sum_w        = {1'b0, i_set_q} + {1'b0, rise_l_q};
        add_val      = (sum_w > {1'b0, ip_l_q}) ? ip_l_q : sum_w[DW-1:0];
        t_inc        = {1'b0, t_q} + {{TW{1'b0}}, 1'b1};
        t_sat        = (&t_q) ? t_q : t_inc[TW-1:0];
        is_tri       = (mode_q == MODE_TRI);
        is_rect      = (mode_q == MODE_RECT);
        ton_hit      = (t_inc >= {1'b0, ton_l_q});
        rise_lim_hit = is_tri ? (t_inc >= {1'b0, (ton_l_q >> 1)}) : ton_hit;
        start_ok     = ((bus.waveform == MODE_RECT) || (bus.waveform == MODE_TRI) ||
                        (bus.waveform == MODE_TRAP)) && (bus.Ton_timer != '0);
        first_rise   = (bus.rise_step < bus.Ip) ? bus.rise_step : bus.Ip;
    end

    // Profile FSM with registered setpoint and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            t_q      <= '0;
            mode_q   <= '0;
            ton_l_q  <= '0;
            ip_l_q   <= '0;
            rise_l_q <= '0;
            fall_l_q <= '0;
            i_set_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    i_set_q <= '0;
                    if (bus.start) begin
                        if (start_ok) begin
                            mode_q   <= bus.waveform;
                            ton_l_q  <= bus.Ton_timer;
                            ip_l_q   <= bus.Ip;
                            rise_l_q <= bus.rise_step;
                            fall_l_q <= bus.fall_step;
                            t_q      <= '0;
                            busy_q   <= 1'b1;
                            if (bus.waveform == MODE_RECT) begin
                                state_q <= HOLD;
                                i_set_q <= bus.Ip;
                            end else begin
                                state_q <= RISE;
                                i_set_q <= first_rise;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RISE: begin
                    t_q <= t_sat;
                    if (bus.abort) begin
                        state_q <= FALL;
                        i_set_q <= sub_val;
                    end else if ((i_set_q == ip_l_q) || rise_lim_hit) begin
                        if (is_tri || ton_hit) begin
                            state_q <= FALL;
                            i_set_q <= sub_val;
                        end else begin
                            state_q <= HOLD;
                        end
                    end else begin
                        i_set_q <= add_val;
                    end
                end
                HOLD: begin
                    t_q <= t_sat;
                    if (bus.abort || ton_hit) begin
                        if (is_rect) begin
                            state_q <= IDLE;
                            i_set_q <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= FALL;
                            i_set_q <= sub_val;
                        end
                    end
                end
                default: begin
                    i_set_q <= sub_val;
                    if (sub_val == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.i_set = i_set_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_i_set_profile_gen.sv
// tb/tb_i_set_profile_gen.sv - randomized self-checking bench for i_set_profile_gen
module tb_i_set_profile_gen;
    localparam int DW = 16;
    localparam int TW = 16;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   exp_q[$];

    i_set_profile_gen_if #(.DW(DW), .TW(TW)) bus ();

    i_set_profile_gen #(.DW(DW), .TW(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic int sat_sub(input int a, input int b);
        return (a > b) ? a - b : 0;
    endfunction

    // Expected i_set per cycle following the start edge; the last entry is the
    // IDLE cycle carrying the done pulse.
    task automatic build_exp(input int mode, input int ton, input int ip, input int rs,
                             input int fs, input int ab);
        int f;
        int v;
        int lim;
        int k;
        int nup;
        int e;
        exp_q.delete();
        f = (fs == 0) ? 65535 : fs;
        if (mode == 1) begin
            for (int i = 0; i < ton; i++) exp_q.push_back(ip);
        end else begin
            lim = (mode == 2) ? ton / 2 : ton;
            v = (rs < ip) ? rs : ip;
            k = 0;
            exp_q.push_back(v);
            while (!(v == ip || k + 1 >= lim)) begin
                v = (v + rs > ip) ? ip : v + rs;
                k++;
                exp_q.push_back(v);
            end
            if (mode == 4 && k + 1 < ton)
                for (int i = k + 1; i < ton; i++) exp_q.push_back(ip);
        end
        nup = exp_q.size();
        if (ab >= 0 && ab < nup)
            while (exp_q.size() > ab + 1) void'(exp_q.pop_back());
        if (mode == 1) begin
            exp_q.push_back(0);
        end else begin
            e = sat_sub(exp_q[exp_q.size() - 1], f);
            exp_q.push_back(e);
            do begin
                e = sat_sub(e, f);
                exp_q.push_back(e);
            end while (e != 0);
        end
    endtask

    // Caller must be at a falling edge. Returns at a falling edge.
    task automatic run_profile(input string tag, input int mode, input int ton, input int ip,
                               input int rs, input int fs, input int ab, input int junk);
        int n;
        build_exp(mode, ton, ip, rs, fs, ab);
        n = exp_q.size();
        bus.waveform  = 16'(mode);
        bus.Ton_timer = TW'(ton);
        bus.Ip        = DW'(ip);
        bus.rise_step = DW'(rs);
        bus.fall_step = DW'(fs);
        bus.abort     = 1'b0;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int j = 0; j < n; j++) begin
            check({tag, ".i_set"}, 32'(bus.i_set), 32'(exp_q[j]));
            check({tag, ".busy"}, 32'(bus.busy), 32'(j < n - 1));
            check({tag, ".done"}, 32'(bus.done), 32'(j == n - 1));
            bus.abort = (j == ab) && (j < n - 1);
            if (j == junk && j < n - 1) begin
                bus.start     = 1'b1;
                bus.waveform  = 16'h0001;
                bus.Ton_timer = TW'($urandom_range(1, 50));
                bus.Ip        = DW'($urandom_range(0, 1000));
                bus.rise_step = DW'($urandom_range(0, 200));
                bus.fall_step = DW'($urandom_range(0, 200));
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check({tag, ".post_i_set"}, 32'(bus.i_set), 32'd0);
        check({tag, ".post_busy"}, 32'(bus.busy), 32'd0);
        check({tag, ".post_done"}, 32'(bus.done), 32'd0);
    endtask

    task automatic run_reject(input string tag, input int mode, input int ton);
        bus.waveform  = 16'(mode);
        bus.Ton_timer = TW'(ton);
        bus.Ip        = DW'($urandom_range(1, 500));
        bus.rise_step = DW'($urandom_range(1, 100));
        bus.fall_step = DW'($urandom_range(1, 100));
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, ".err"}, 32'(bus.err), 32'd1);
        check({tag, ".busy"}, 32'(bus.busy), 32'd0);
        check({tag, ".i_set"}, 32'(bus.i_set), 32'd0);
        @(negedge clk);
        check({tag, ".err_clr"}, 32'(bus.err), 32'd0);
        check({tag, ".busy2"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int modes[3];
        int bad[4];
        int m;
        int ton;
        int ip;
        int rs;
        int fs;
        int ab;
        int jk;
        n_tests = 0;
        n_fail  = 0;
        modes[0] = 1; modes[1] = 2; modes[2] = 4;
        bad[0] = 16'h8000; bad[1] = 0; bad[2] = 3; bad[3] = 16'h0010;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.waveform  = '0;
        bus.Ton_timer = '0;
        bus.Ip        = '0;
        bus.rise_step = '0;
        bus.fall_step = '0;
        repeat (2) @(negedge clk);
        check("reset.i_set", 32'(bus.i_set), 32'd0);
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.done", 32'(bus.done), 32'd0);
        check("reset.err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;

        run_profile("rect", 1, 5, 100, 0, 0, -1, -1);
        run_profile("trap", 4, 10, 100, 40, 50, -1, 3);
        run_profile("tri", 2, 8, 100, 30, 30, -1, 2);
        run_profile("trap_abort", 4, 10, 100, 40, 50, 4, 1);
        run_profile("rect_abort", 1, 9, 77, 0, 0, 3, 1);
        run_profile("tri_abort_rise", 2, 20, 500, 25, 60, 2, -1);
        run_profile("fall_zero", 4, 6, 300, 100, 0, -1, -1);
        run_profile("ton1_tri", 2, 1, 50, 10, 5, -1, -1);
        run_reject("rej_8000", 16'h8000, 5);
        run_reject("rej_ton0", 1, 0);

        for (int r = 0; r < 40; r++) begin
            m  = modes[$urandom_range(0, 2)];
            ton = $urandom_range(1, 24);
            ip = $urandom_range(0, 300);
            rs = $urandom_range(0, 120);
            fs = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 120);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 20) : -1;
            jk = $urandom_range(0, 10);
            run_profile("rand", m, ton, ip, rs, fs, ab, jk);
            if ($urandom_range(0, 3) == 0)
                run_reject("rand_rej", bad[$urandom_range(0, 3)], $urandom_range(0, 1) ? 0 : 7);
        end

        // Reset asserted asynchronously mid-RISE, then a start on the first edge after release.
        bus.waveform  = 16'h0004;
        bus.Ton_timer = TW'(20);
        bus.Ip        = DW'(400);
        bus.rise_step = DW'(30);
        bus.fall_step = DW'(100);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("pre_rst.i_set", 32'(bus.i_set), 32'd60);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst.i_set", 32'(bus.i_set), 32'd0);
        check("async_rst.busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_profile("after_rst", 2, 8, 100, 30, 30, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/i_set_profile_gen.md
I_SET_PROFILE_GEN -- requirements
Module: i_set_profile_gen

Interface
REQ-001 SHALL have parameter DW, default 16, width of all current quantities.
REQ-002 SHALL have parameter TW, default 16, width of on-time timer.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse requesting a discharge profile.
REQ-006 SHALL have port abort  input  1  level; forces ramp-down of an active profile.
REQ-007 SHALL have port waveform  input  16  mode: 0x0001 rectangle, 0x0002 triangle, 0x0004 trapezoid, 0x8000 resistor discharge.
REQ-008 SHALL have port Ton_timer  input  TW  on-time in clk cycles.
REQ-009 SHALL have port Ip  input  DW  peak current setpoint.
REQ-010 SHALL have port rise_step  input  DW  current increment per cycle in RISE.
REQ-011 SHALL have port fall_step  input  DW  current decrement per cycle in FALL.
REQ-012 SHALL have port i_set  output  DW  registered current setpoint.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse on return to IDLE from an active state.
REQ-015 SHALL have port err  output  1  one-cycle pulse on a rejected start.

Function
REQ-016 SHALL implement states IDLE, RISE, HOLD, FALL; timer t (TW bits) and latched mode/Ton_L/Ip_L/rise_L/fall_L.
REQ-017 SHALL, on the edge sampling start in IDLE with a supported ramp or rectangle mode and Ton_timer!=0, latch all parameters, set t=0, assert busy.
REQ-018 SHALL on that edge enter HOLD with i_set=Ip for rectangle; enter RISE with i_set=min(rise_step,Ip) for triangle/trapezoid.
REQ-019 SHALL reject start when waveform is not one of 0x0001/0x0002/0x0004 or Ton_timer==0: pulse err, stay IDLE, i_set unchanged; 0x8000 is rejected the same way.
REQ-020 SHALL ignore start while busy; inputs other than abort have no effect mid-profile (latched copies used).
REQ-021 SHALL increment t by 1 each cycle in RISE/HOLD, saturating at all-ones.
REQ-022 SHALL in RISE: if i_set==Ip_L or t>=(Ton_L>>1)-1 (triangle) / t>=Ton_L-1 (trapezoid) exit; triangle -> FALL, trapezoid -> HOLD (or FALL if t>=Ton_L-1); else i_set=min(i_set+rise_L,Ip_L).
REQ-023 SHALL compute sums/differences in DW+1 bits; never wrap.
REQ-024 SHALL in HOLD keep i_set=Ip_L until t==Ton_L-1; next edge: rectangle -> IDLE with i_set=0 and done; trapezoid -> FALL with i_set=sat_sub(i_set,fall_L).
REQ-025 SHALL on entering FALL from RISE load i_set=sat_sub(i_set,fall_L).
REQ-026 SHALL in FALL set i_set=sat_sub(i_set,fall_L) each edge; when result is 0 enter IDLE and pulse done on that edge.
REQ-027 SHALL treat fall_L==0 as fall_L=max value (single-step drop to 0) to prevent lock-up.
REQ-028 SHALL on abort in RISE/HOLD (ramp modes) enter FALL next edge; rectangle goes straight to IDLE with i_set=0; done pulses once.
REQ-029 SHALL give abort priority over all other transitions; abort in IDLE or FALL has no extra effect.
REQ-030 SHALL hold i_set=0 in IDLE.

Reset
REQ-031 SHALL on rst_n low immediately force IDLE, i_set=0, busy=0, done=0, err=0, t=0, latched registers 0, including mid-profile.
REQ-032 SHALL accept start on the first edge after rst_n deasserts.

Verification
REQ-033 Rectangle Ip=100 Ton=5 -> i_set 100 for 5 cycles, then 0 with done pulse; busy high 5 cycles.
REQ-034 Trapezoid Ip=100 rise=40 fall=50 Ton=10 -> i_set 40,80,100x8,50,0; done on cycle i_set returns 0.
REQ-035 Triangle Ip=100 rise=30 fall=30 Ton=8 -> i_set 30,60,90,100,70,40,10,0; done once.
REQ-036 Trapezoid above with abort in HOLD at t=4 -> next cycles 50,0; done once; start during profile ignored.
REQ-037 waveform=0x8000 or Ton=0 with start -> err one cycle, busy=0, i_set=0.
REQ-038 rst_n pulsed low mid-RISE -> i_set=0, busy=0 asynchronously; clean restart on next start.
